// File: rtl/ps2_host_tx_if.sv
// Command-byte interface between a requester and the PS/2 host transmitter.
// A byte moves on a cycle where tx_valid && tx_ready. tx_ready is high only while the transmitter is idle.
// done/err are single-cycle results, and err_code holds until the next byte is accepted.
interface ps2_host_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    modport master (
        output tx_valid, tx_data,
        input  tx_ready, done, err, err_code
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ready, done, err, err_code
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, then clock out one
// odd-parity frame on the device's falling edges and check the device's ack bit.
module ps2_host_tx #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned INHIBIT_US  = 100,
    parameter int unsigned TIMEOUT_US  = 2000,
    parameter int unsigned RTS_CYC     = 4
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    ps2_host_tx_if.slave tx,
    input  logic         ps2_clk_i,
    input  logic         ps2_data_i,
    output logic         ps2_clk_oe_o,
    output logic         ps2_data_oe_o,
    output logic [2:0]   dbg_state_o
);

    localparam int unsigned INH_CYC = CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
    localparam int unsigned TO_CYC  = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
    localparam int unsigned CNT_W   = $clog2(((INH_CYC > RTS_CYC) ? INH_CYC : RTS_CYC) + 1);
    localparam int unsigned TO_W    = $clog2(TO_CYC + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INHIBIT = 3'd1;
    localparam logic [2:0] S_RTS     = 3'd2;
    localparam logic [2:0] S_SHIFT   = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [9:0]       frame_q, frame_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             hi_cnt_q, hi_cnt_d;
    // clk_sync: [0]/[1] synchroniser stages, [2] previous synchronised value
    logic [2:0]       clk_sync_q, clk_sync_d;
    logic [1:0]       dat_sync_q, dat_sync_d;

    logic kfall, clk_s, dat_s;

    assign clk_s = clk_sync_q[1];
    assign dat_s = dat_sync_q[1];
    assign kfall = clk_sync_q[2] & ~clk_sync_q[1];

    always_comb begin
        clk_sync_d = {clk_sync_q[1:0], ps2_clk_i};
        dat_sync_d = {dat_sync_q[0], ps2_data_i};
        state_d    = state_q;
        cyc_d      = cyc_q;
        to_d       = to_q;
        bit_cnt_d  = bit_cnt_q;
        frame_d    = frame_q;
        clk_oe_d   = clk_oe_q;
        data_oe_d  = data_oe_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        hi_cnt_d   = hi_cnt_q;

        case (state_q)
            S_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx.tx_valid) begin
                    frame_d    = {1'b1, ~^tx.tx_data, tx.tx_data};
                    err_code_d = 2'b00;
                    cyc_d      = '0;
                    clk_oe_d   = 1'b1;
                    state_d    = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cyc_q == CNT_W'(INH_CYC - 1)) begin
                    cyc_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = S_RTS;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_RTS: begin
                // Start bit stays driven low after the clock is released.
                if (cyc_q == CNT_W'(RTS_CYC - 1)) begin
                    clk_oe_d  = 1'b0;
                    bit_cnt_d = '0;
                    to_d      = '0;
                    state_d   = S_SHIFT;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (kfall) begin
                    to_d = '0;
                    if (bit_cnt_q != 4'd10) begin
                        data_oe_d = ~frame_q[bit_cnt_q];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else begin
                        data_oe_d = 1'b0;
                        hi_cnt_d  = 1'b0;
                        state_d   = S_RELEASE;
                        if (!dat_s) begin
                            done_d = 1'b1;
                        end else begin
                            err_d      = 1'b1;
                            err_code_d = 2'b01;
                        end
                    end
                end else if (to_q == TO_W'(TO_CYC - 1)) begin
                    clk_oe_d   = 1'b0;
                    data_oe_d  = 1'b0;
                    err_d      = 1'b1;
                    err_code_d = 2'b10;
                    hi_cnt_d   = 1'b0;
                    state_d    = S_RELEASE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_RELEASE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (clk_s && dat_s) begin
                    hi_cnt_d = 1'b1;
                    if (hi_cnt_q) begin
                        hi_cnt_d = 1'b0;
                        state_d  = S_IDLE;
                    end
                end else begin
                    hi_cnt_d = 1'b0;
                end
            end
            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q    <= S_IDLE;
            cyc_q      <= '0;
            to_q       <= '0;
            bit_cnt_q  <= '0;
            frame_q    <= '0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            hi_cnt_q   <= 1'b0;
            clk_sync_q <= 3'b111;
            dat_sync_q <= 2'b11;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            to_q       <= to_d;
            bit_cnt_q  <= bit_cnt_d;
            frame_q    <= frame_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            hi_cnt_q   <= hi_cnt_d;
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
        end
    end

    assign tx.tx_ready   = (state_q == S_IDLE);
    assign tx.done       = done_q;
    assign tx.err        = err_q;
    assign tx.err_code   = err_code_q;
    assign ps2_clk_oe_o  = clk_oe_q;
    assign ps2_data_oe_o = data_oe_q;
    assign dbg_state_o   = state_q;

endmodule
